// File: rtl/seq_ctrl_pkg.sv
// Shared definitions for the serial pattern-detector run controller.
package seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ARM  = 2'b01,
        ST_RUN  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    localparam int PAT_W_DEF = 4;
    localparam int CNT_W_DEF = 8;
    localparam int TMO_W_DEF = 16;

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// Start/done handshake, run configuration and serial stream between control logic and detector.
interface seq_detect_ctrl_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int TMO_W = 16
);
    logic             start;
    logic             abort;
    logic [PAT_W-1:0] pattern;
    logic             overlap;
    logic [CNT_W-1:0] match_target;
    logic [TMO_W-1:0] timeout;
    logic             in;
    logic             in_valid;
    logic             busy;
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic             done;
    logic             timed_out;
    logic [1:0]       pre_s;

    modport master (
        output start, abort, pattern, overlap, match_target, timeout, in, in_valid,
        input  busy, match, match_cnt, done, timed_out, pre_s
    );

    modport slave (
        input  start, abort, pattern, overlap, match_target, timeout, in, in_valid,
        output busy, match, match_cnt, done, timed_out, pre_s
    );
endinterface

// File: rtl/seq_shift_match.sv
// Serial shift register with fill tracking; hit is the match decision for the bit being shifted in now.
module seq_shift_match #(
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             in_bit,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    output logic             hit
);
    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  sr_q, sr_d;
    logic [FILL_W-1:0] fill_q, fill_d, fill_inc;

    always_comb begin
        sr_d     = sr_q;
        fill_d   = fill_q;
        hit      = 1'b0;
        fill_inc = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
        if (clr) begin
            sr_d   = '0;
            fill_d = '0;
        end else if (shift_en) begin
            sr_d   = {sr_q[PAT_W-2:0], in_bit};
            hit    = (fill_inc == FILL_FULL) && (sr_d == pattern);
            // Non-overlapping mode: the next match must be built from fresh bits only.
            fill_d = (hit && !overlap) ? '0 : fill_inc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_q   <= '0;
            fill_q <= '0;
        end else begin
            sr_q   <= sr_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run controller for the serial pattern detector: latches a run config, counts matches,
// and ends on target or timeout through a 4-phase start/done handshake.
//   state | meaning
//   IDLE  | waiting for start; config sampled here
//   ARM   | one cycle, clears detector and timeout counter
//   RUN   | detecting; counts matches and RUN cycles
//   DONE  | result held until start drops
module seq_detect_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int TMO_W = 16
) (
    input logic              clk,
    input logic              reset,
    seq_detect_ctrl_if.slave bus
);
    state_e           state_q, state_d;
    logic [PAT_W-1:0] cfg_pattern_q, cfg_pattern_d;
    logic             cfg_overlap_q, cfg_overlap_d;
    logic [CNT_W-1:0] cfg_target_q, cfg_target_d;
    logic [TMO_W-1:0] cfg_timeout_q, cfg_timeout_d;
    logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timed_out_q, timed_out_d;
    logic             match_q, match_d;

    logic             clr, shift_en, hit;
    logic [CNT_W-1:0] cnt_inc;
    logic             target_hit, tmo_hit;

    assign clr      = (state_q == ST_ARM);
    assign shift_en = (state_q == ST_RUN) && !bus.abort && bus.in_valid;

    seq_shift_match #(.PAT_W(PAT_W)) u_shift_match (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr),
        .shift_en (shift_en),
        .in_bit   (bus.in),
        .pattern  (cfg_pattern_q),
        .overlap  (cfg_overlap_q),
        .hit      (hit)
    );

    assign cnt_inc    = (match_cnt_q == '1) ? match_cnt_q : match_cnt_q + CNT_W'(1);
    assign target_hit = (cfg_target_q != '0) && (cnt_inc == cfg_target_q);
    assign tmo_hit    = (cfg_timeout_q != '0) && (tmo_cnt_q == cfg_timeout_q - TMO_W'(1));

    always_comb begin
        state_d       = state_q;
        cfg_pattern_d = cfg_pattern_q;
        cfg_overlap_d = cfg_overlap_q;
        cfg_target_d  = cfg_target_q;
        cfg_timeout_d = cfg_timeout_q;
        match_cnt_d   = match_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        timed_out_d   = timed_out_q;
        match_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    cfg_pattern_d = bus.pattern;
                    cfg_overlap_d = bus.overlap;
                    cfg_target_d  = bus.match_target;
                    cfg_timeout_d = bus.timeout;
                    match_cnt_d   = '0;
                    timed_out_d   = 1'b0;
                    state_d       = ST_ARM;
                end
            end
            ST_ARM: begin
                if (bus.abort) begin
                    timed_out_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    tmo_cnt_d = '0;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    timed_out_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                    if (hit) begin
                        match_d     = 1'b1;
                        match_cnt_d = cnt_inc;
                    end
                    // A target-reaching match on the timeout edge is reported as success.
                    if (hit && target_hit) begin
                        timed_out_d = 1'b0;
                        state_d     = ST_DONE;
                    end else if (tmo_hit) begin
                        timed_out_d = 1'b1;
                        state_d     = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (bus.abort) begin
                    timed_out_d = 1'b0;
                    state_d     = ST_IDLE;
                end else if (!bus.start) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            cfg_pattern_q <= '0;
            cfg_overlap_q <= 1'b0;
            cfg_target_q  <= '0;
            cfg_timeout_q <= '0;
            match_cnt_q   <= '0;
            tmo_cnt_q     <= '0;
            timed_out_q   <= 1'b0;
            match_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cfg_pattern_q <= cfg_pattern_d;
            cfg_overlap_q <= cfg_overlap_d;
            cfg_target_q  <= cfg_target_d;
            cfg_timeout_q <= cfg_timeout_d;
            match_cnt_q   <= match_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            timed_out_q   <= timed_out_d;
            match_q       <= match_d;
        end
    end

    assign bus.busy      = (state_q == ST_ARM) || (state_q == ST_RUN);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.timed_out = (state_q == ST_DONE) && timed_out_q;
    assign bus.match     = match_q;
    assign bus.match_cnt = match_cnt_q;
    assign bus.pre_s     = state_q;

endmodule
